// File: rtl/fall_detector.sv
// fall_detector
//   Per-frame hazard monitor feeding the game-state controller. Once per
//   frame (rising edge of frame_clk, detected in the Clk domain) it samples
//   the player's Y position, vertical velocity and monster-collision flag.
//   From these it produces debounced, sticky death/drop levels and a
//   one-cycle stomp pulse.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous, active-low reset
//   frame_clk    frame strobe, edge-detected internally
//   restart      controller level; returns the block to IDLE
//   player_y     signed player top-edge Y (top of screen = 0)
//   player_vy    signed vertical velocity (positive = downward)
//   monster_hit  sprite overlaps a monster
//   death        sticky, set after HIT_FRAMES consecutive lethal hits
//   drop         sticky, set after DROP_FRAMES consecutive off-screen frames
//   stomp        one-Clk pulse on a downward monster hit while staying alive
//   alive        high while in ALIVE
module fall_detector #(
  parameter int Y_W           = 11,
  parameter int VY_W          = 10,
  parameter int SCREEN_BOTTOM = 479,
  parameter int DROP_FRAMES   = 2,
  parameter int HIT_FRAMES    = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   restart,
  input  logic signed [Y_W-1:0]  player_y,
  input  logic signed [VY_W-1:0] player_vy,
  input  logic                   monster_hit,
  output logic                   death,
  output logic                   drop,
  output logic                   stomp,
  output logic                   alive
);

  typedef enum logic [1:0] {IDLE, ALIVE, DROPPED, DEAD} state_t;

  // Typed signed constants keep every compare below fully signed.
  localparam logic signed [Y_W-1:0]  Y_BOTTOM = Y_W'(SCREEN_BOTTOM);
  localparam logic signed [VY_W-1:0] VY_ZERO  = '0;
  localparam logic [3:0]             DROP_TH  = 4'(DROP_FRAMES);
  localparam logic [3:0]             HIT_TH   = 4'(HIT_FRAMES);

  state_t     state, state_nxt;
  logic [3:0] fall_cnt, hit_cnt, fall_nxt, hit_nxt;
  logic       f_q1, f_q2, tick;
  logic       lethal, stomp_ev, off, stomp_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  assign tick     = f_q1 & ~f_q2;
  assign off      = player_y > Y_BOTTOM;
  assign lethal   = monster_hit & (player_vy <= VY_ZERO);
  assign stomp_ev = monster_hit & (player_vy > VY_ZERO);

  always_comb begin
    state_nxt = state;
    fall_nxt  = fall_cnt;
    hit_nxt   = hit_cnt;
    stomp_nxt = 1'b0;
    if (restart) begin
      state_nxt = IDLE;
      fall_nxt  = '0;
      hit_nxt   = '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          fall_nxt = '0;
          hit_nxt  = '0;
          if (!off) state_nxt = ALIVE;
        end
        ALIVE: begin
          hit_nxt  = lethal ? sat_inc(hit_cnt)  : 4'd0;
          fall_nxt = off    ? sat_inc(fall_cnt) : 4'd0;
          // Death outranks drop when both thresholds land on the same frame;
          // a stomp only counts if the player survives this frame.
          if (lethal && hit_nxt == HIT_TH)
            state_nxt = DEAD;
          else if (off && fall_nxt == DROP_TH)
            state_nxt = DROPPED;
          else
            stomp_nxt = stomp_ev;
        end
        default: ;
      endcase
    end
  end

  // Frame-strobe synchroniser / edge detector, then state and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      f_q1     <= 1'b0;
      f_q2     <= 1'b0;
      state    <= IDLE;
      fall_cnt <= '0;
      hit_cnt  <= '0;
      death    <= 1'b0;
      drop     <= 1'b0;
      stomp    <= 1'b0;
      alive    <= 1'b0;
    end else begin
      f_q1     <= frame_clk;
      f_q2     <= f_q1;
      state    <= state_nxt;
      fall_cnt <= fall_nxt;
      hit_cnt  <= hit_nxt;
      death    <= (state_nxt == DEAD);
      drop     <= (state_nxt == DROPPED);
      stomp    <= stomp_nxt;
      alive    <= (state_nxt == ALIVE);
    end
  end

endmodule

// File: tb/tb_fall_detector.sv
module tb_fall_detector;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               frame_clk;
  logic               restart;
  logic signed [10:0] player_y;
  logic signed [9:0]  player_vy;
  logic               monster_hit;
  logic               death, drop, stomp, alive;

  int n_tests = 0;
  int n_fail  = 0;
  logic stomp_p, stomp_after;

  fall_detector dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .restart(restart),
    .player_y(player_y), .player_vy(player_vy), .monster_hit(monster_hit),
    .death(death), .drop(drop), .stomp(stomp), .alive(alive)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One frame: outputs are sampled just after the 2nd Clk edge following the
  // frame_clk rise, then once more a cycle later to see stomp drop back.
  task automatic do_frame();
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1 stomp_p = stomp;
    @(negedge Clk) frame_clk = 1'b0;
    @(posedge Clk);
    #1 stomp_after = stomp;
  endtask

  task automatic pulse_restart();
    @(negedge Clk) restart = 1'b1;
    @(negedge Clk) restart = 1'b0;
  endtask

  task automatic set_in(input int y, input int vy, input logic hit);
    player_y    = 11'(y);
    player_vy   = 10'(vy);
    monster_hit = hit;
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; restart = 1'b1;
    set_in(100, 0, 1'b0);
    #2;
    check("reset_death", death, 1'b0);
    check("reset_drop",  drop,  1'b0);
    check("reset_alive", alive, 1'b0);
    check("reset_stomp", stomp, 1'b0);
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) restart = 1'b0;

    // Arm
    do_frame();
    check("arm_alive", alive, 1'b1);
    check("arm_death", death, 1'b0);
    check("arm_drop",  drop,  1'b0);

    // Drop debounce: single excursion, recovery, boundary row, held strobe
    set_in(480, 0, 1'b0); do_frame();
    check("exc1_drop",  drop,  1'b0);
    check("exc1_alive", alive, 1'b1);
    set_in(470, 0, 1'b0); do_frame();
    check("recov_drop", drop, 1'b0);
    set_in(480, 0, 1'b0); do_frame();
    check("off1_drop", drop, 1'b0);
    set_in(479, 0, 1'b0); do_frame();
    check("edge479_drop", drop, 1'b0);
    set_in(480, 0, 1'b0);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    #1 check("held_one_tick_drop", drop, 1'b0);
    @(negedge Clk) frame_clk = 1'b0;
    do_frame();
    check("off2_drop",  drop,  1'b1);
    check("off2_alive", alive, 1'b0);
    set_in(100, 0, 1'b0); do_frame();
    check("dropped_sticky", drop, 1'b1);

    // Restart, stomp, lethal hits
    pulse_restart();
    #1 check("rst_drop", drop, 1'b0);
    do_frame();
    check("rearm_alive", alive, 1'b1);
    set_in(100, 3, 1'b1); do_frame();
    check("stomp_pulse", stomp_p,     1'b1);
    check("stomp_clear", stomp_after, 1'b0);
    check("stomp_death", death,       1'b0);
    set_in(100, -4, 1'b1); do_frame();
    check("hit1_stomp", stomp_p, 1'b0);
    check("hit1_death", death,   1'b0);
    do_frame();
    check("hit2_stomp", stomp_p, 1'b0);
    check("hit2_death", death,   1'b1);
    check("hit2_alive", alive,   1'b0);

    // Death outranks drop on the same frame
    pulse_restart();
    set_in(100, 0, 1'b0); do_frame();
    set_in(500, 0, 1'b1); do_frame();
    check("both1_death", death, 1'b0);
    check("both1_drop",  drop,  1'b0);
    do_frame();
    check("both2_death", death, 1'b1);
    check("both2_drop",  drop,  1'b0);

    // DEAD ignores inputs for 10 frames
    for (int i = 0; i < 10; i++) begin
      set_in(i * 60, 5 - i, i[0]); do_frame();
      check("dead_hold", death, 1'b1);
      check("dead_no_stomp", stomp_p, 1'b0);
    end

    // Restart coincident with tick wins; IDLE must not re-arm that edge
    set_in(100, 0, 1'b0);
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    #1 restart = 1'b1;
    @(posedge Clk);
    #1 check("coinc_death", death, 1'b0);
    check("coinc_alive", alive, 1'b0);
    restart = 1'b0;
    @(negedge Clk) frame_clk = 1'b0;
    set_in(600, 0, 1'b0); do_frame();
    check("idle600_a", alive, 1'b0);
    do_frame();
    check("idle600_b", alive, 1'b0);
    set_in(-5, 0, 1'b0); do_frame();
    check("neg_y_alive", alive, 1'b1);

    // Async reset while dropped
    set_in(480, 0, 1'b0); do_frame(); do_frame();
    check("pre_reset_drop", drop, 1'b1);
    @(posedge Clk) #3 Reset = 1'b0;
    #1 check("async_drop", drop, 1'b0);
    check("async_alive", alive, 1'b0);
    @(negedge Clk) Reset = 1'b1;
    set_in(100, 0, 1'b0); do_frame();
    check("post_reset_alive", alive, 1'b1);
    check("post_reset_drop",  drop,  1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
